// File: rtl/encoder_pkg.sv
// Shared types and helpers for the request encoder family.
package encoder_pkg;

    typedef enum logic {ENC_EMPTY, ENC_FULL} enc_state_t;

    localparam int unsigned ENC_N_DEFAULT = 4;
    localparam int unsigned ENC_MAX_N     = 32;

    typedef struct packed {
        logic        found;
        logic [31:0] idx;
    } enc_pick_t;

    // First set bit of vec[n-1:0], scanning upward from start and wrapping at n.
    function automatic enc_pick_t first_set_from(
        input logic [ENC_MAX_N-1:0] vec,
        input int unsigned          n,
        input int unsigned          start
    );
        enc_pick_t   r;
        int unsigned j;
        r = '0;
        for (int unsigned k = 0; k < ENC_MAX_N; k++) begin
            if (k < n) begin
                j = (start + k) % n;
                if (!r.found && vec[j[4:0]]) begin
                    r.found = 1'b1;
                    r.idx   = j;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_encoder_4_2_pick.sv
// Combinational grant selection: round-robin after last_ptr, or highest index.
module rr_pick
    import encoder_pkg::*;
#(
    parameter  int unsigned N  = ENC_N_DEFAULT,
    parameter  int unsigned RR = 1,
    localparam int unsigned W  = $clog2(N)
) (
    input  logic [N-1:0] cand,
    input  logic [W-1:0] last_ptr,
    output logic [W-1:0] g,
    output logic         any
);

    logic [W-1:0] start_ptr;
    logic [W-1:0] hi_idx;
    enc_pick_t    rr_res;

    // Both policies are evaluated; RR chooses which one drives the grant.
    always_comb begin
        start_ptr = last_ptr + W'(1);
        rr_res    = first_set_from(ENC_MAX_N'(cand), N, 32'(start_ptr));
        hi_idx    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (cand[i[W-1:0]]) hi_idx = W'(i);
        end
        g   = (RR != 0) ? W'(rr_res.idx) : hi_idx;
        any = (RR != 0) ? rr_res.found   : (|cand);
    end

endmodule

// File: rtl/rr_encoder_4_2.sv
// Sticky-request encoder: latches request bits and presents one index at a
// time on a valid/ready port, round-robin or highest-index-first.
module rr_encoder_4_2
    import encoder_pkg::*;
#(
    parameter  int unsigned N  = ENC_N_DEFAULT,
    parameter  int unsigned RR = 1,
    localparam int unsigned W  = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic [W-1:0] y,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] pending,
    output logic         idle
);

    enc_state_t   state, state_nxt;
    logic [W-1:0] last_ptr, last_nxt, y_nxt, g;
    logic [N-1:0] cand, cand_acc, y_mask, pending_nxt;
    logic         accept, load, any;

    // Candidate set; an accepted index drops out unless re-requested this cycle.
    always_comb begin
        cand     = pending | req;
        y_mask   = N'(1) << y;
        accept   = (state == ENC_FULL) && out_ready;
        cand_acc = accept ? (cand & ~(y_mask & ~req)) : cand;
        load     = (state == ENC_EMPTY) || accept;
    end

    rr_pick #(.N(N), .RR(RR)) u_pick (
        .cand     (cand_acc),
        .last_ptr (last_ptr),
        .g        (g),
        .any      (any)
    );

    // Next-state: reload the output slot when empty or accepted, else accumulate.
    always_comb begin
        state_nxt   = state;
        y_nxt       = y;
        last_nxt    = last_ptr;
        pending_nxt = pending | req;
        if (load) begin
            if (any) begin
                state_nxt   = ENC_FULL;
                y_nxt       = g;
                last_nxt    = g;
                pending_nxt = cand_acc & ~(N'(1) << g);
            end else begin
                state_nxt   = ENC_EMPTY;
                pending_nxt = cand_acc;
            end
        end
    end

    // State register; reset drops all pending requests and any unaccepted grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ENC_EMPTY;
            y        <= '0;
            last_ptr <= W'(N - 1);
            pending  <= '0;
        end else begin
            state    <= state_nxt;
            y        <= y_nxt;
            last_ptr <= last_nxt;
            pending  <= pending_nxt;
        end
    end

    // Status outputs derived from registers only.
    always_comb begin
        out_valid = (state == ENC_FULL);
        idle      = (pending == '0) && (state == ENC_EMPTY);
    end

endmodule

// File: tb/tb_rr_encoder_4_2.sv
// Self-checking bench: round-robin and fixed-priority instances driven in
// parallel and compared against a behavioural model of the grant rules.
module tb_rr_encoder_4_2;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0;
    logic       out_ready = 1'b0;

    logic [1:0] y_rr, y_fp;
    logic       v_rr, v_fp, idle_rr, idle_fp;
    logic [3:0] p_rr, p_fp;

    int vectors = 0;
    int errors  = 0;

    // Model state, index 0 = round-robin, 1 = fixed priority
    bit [3:0] m_pend [2];
    bit       m_valid[2];
    int       m_y    [2];
    int       m_last [2];

    rr_encoder_4_2 #(.N(4), .RR(1)) u_rr (
        .clk(clk), .rst_n(rst_n), .req(req), .y(y_rr), .out_valid(v_rr),
        .out_ready(out_ready), .pending(p_rr), .idle(idle_rr)
    );

    rr_encoder_4_2 #(.N(4), .RR(0)) u_fp (
        .clk(clk), .rst_n(rst_n), .req(req), .y(y_fp), .out_valid(v_fp),
        .out_ready(out_ready), .pending(p_fp), .idle(idle_fp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_pend[d] = '0; m_valid[d] = 1'b0; m_y[d] = 0; m_last[d] = N - 1;
        end
    endtask

    // One clock edge of the spec's rules, computed with plain integer search.
    task automatic model_edge(input bit [3:0] r, input bit rd);
        bit [3:0] cand;
        int       g;
        for (int d = 0; d < 2; d++) begin
            cand = m_pend[d] | r;
            if (!m_valid[d] || rd) begin
                if (m_valid[d] && !r[m_y[d]]) cand[m_y[d]] = 1'b0;
                if (cand == 0) begin
                    m_valid[d] = 1'b0;
                    m_pend[d]  = '0;
                end else begin
                    g = -1;
                    if (d == 0) begin
                        for (int k = 1; k <= N; k++)
                            if (g < 0 && cand[(m_last[d] + k) % N]) g = (m_last[d] + k) % N;
                    end else begin
                        for (int j = N - 1; j >= 0; j--)
                            if (g < 0 && cand[j]) g = j;
                    end
                    m_y[d]     = g;
                    m_last[d]  = g;
                    m_valid[d] = 1'b1;
                    cand[g]    = 1'b0;
                    m_pend[d]  = cand;
                end
            end else begin
                m_pend[d] = m_pend[d] | r;
            end
        end
    endtask

    task automatic check_all();
        chk("rr_valid", 32'(v_rr), 32'(m_valid[0]));
        chk("rr_pending", 32'(p_rr), 32'(m_pend[0]));
        chk("rr_idle", 32'(idle_rr), 32'(m_pend[0] == 0 && !m_valid[0]));
        if (m_valid[0]) chk("rr_y", 32'(y_rr), 32'(m_y[0]));
        chk("fp_valid", 32'(v_fp), 32'(m_valid[1]));
        chk("fp_pending", 32'(p_fp), 32'(m_pend[1]));
        chk("fp_idle", 32'(idle_fp), 32'(m_pend[1] == 0 && !m_valid[1]));
        if (m_valid[1]) chk("fp_y", 32'(y_fp), 32'(m_y[1]));
    endtask

    // Drive inputs on the falling edge, update the model on the rising edge, sample 1ns later.
    task automatic cyc(input logic [3:0] r, input logic rd);
        @(negedge clk);
        req = r;
        out_ready = rd;
        @(posedge clk);
        model_edge(r, rd);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req = '0; out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_valid", 32'(v_rr | v_fp), 32'd0);
        chk("reset_pending", 32'({p_rr, p_fp}), 32'd0);
        chk("reset_y", 32'({y_rr, y_fp}), 32'd0);
        chk("reset_idle", 32'(idle_rr & idle_fp), 32'd1);
        rst_n = 1'b1;

        // Single request, one-cycle latency, then empty
        cyc(4'b0001, 1'b1);
        chk("single_y", 32'(y_rr), 32'd0);
        chk("single_valid", 32'(v_rr), 32'd1);
        cyc(4'b0000, 1'b1);
        chk("single_empty", 32'(idle_rr), 32'd1);

        // Round-robin fairness with all lines held
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cyc(4'b1111, 1'b1);
            chk("rr_fair_y", 32'(y_rr), 32'(i % 4));
            chk("rr_fair_valid", 32'(v_rr), 32'd1);
        end
        for (int i = 0; i < 6; i++) cyc(4'b0000, 1'b1);

        // Fixed priority: index 2 always wins over 1
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(4'b0110, 1'b1);
            chk("fp_hold_y", 32'(y_fp), 32'd2);
        end
        cyc(4'b0000, 1'b1);
        chk("fp_drain_y", 32'(y_fp), 32'd1);
        cyc(4'b0000, 1'b1);
        chk("fp_drain_empty", 32'(v_fp), 32'd0);

        // Backpressure: y holds while requests accumulate
        do_reset();
        cyc(4'b0100, 1'b0);
        chk("bp_y_first", 32'(y_rr), 32'd2);
        cyc(4'b1010, 1'b0);
        chk("bp_y_hold", 32'(y_rr), 32'd2);
        chk("bp_pending", 32'(p_rr), 32'b1010);
        cyc(4'b0000, 1'b1);
        chk("bp_y3", 32'(y_rr), 32'd3);
        cyc(4'b0000, 1'b1);
        chk("bp_y1", 32'(y_rr), 32'd1);
        cyc(4'b0000, 1'b1);
        chk("bp_empty", 32'(v_rr), 32'd0);

        // Re-request of the index being accepted
        do_reset();
        cyc(4'b0010, 1'b0);
        chk("rereq_first", 32'(y_rr), 32'd1);
        cyc(4'b0010, 1'b1);
        chk("rereq_y", 32'(y_rr), 32'd1);
        chk("rereq_valid", 32'(v_rr), 32'd1);
        chk("rereq_pending", 32'(p_rr), 32'd0);
        cyc(4'b0000, 1'b1);

        // Asynchronous reset in the middle of a cycle
        do_reset();
        cyc(4'b0100, 1'b0);
        cyc(4'b1011, 1'b0);
        chk("midrst_pre_pending", 32'(p_rr), 32'b1011);
        @(negedge clk);
        req = '0; out_ready = 1'b0;
        @(posedge clk);
        model_edge(4'b0000, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        chk("midrst_pending", 32'({p_rr, p_fp}), 32'd0);
        chk("midrst_valid", 32'(v_rr | v_fp), 32'd0);
        chk("midrst_y", 32'({y_rr, y_fp}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(4'b1000, 1'b1);
        chk("midrst_after_y", 32'(y_rr), 32'd3);
        cyc(4'b0000, 1'b1);

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [3:0] r;
            logic       rd;
            r  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) r = '0;
            rd = ($urandom_range(0, 3) != 0);
            cyc(r, rd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/rr_encoder_4_2.md
Name: rr_encoder_4_2

Overview:
- Sequential encoder, the companion to the team's 2-to-4 decoder: turns one-hot/multi-hot request lines back into a binary index.
- Requests are latched as sticky pending bits. One index at a time is granted, round-robin or fixed priority, and presented on a valid/ready output port.
- Sits in front of the 2-to-4 decoder: the decoder's output `y` is fed back as `req` so that loopback tests close the path.

Parameters:
- N, 4, number of request lines (power of 2, ≥2)
- W, $clog2(N), index width (derived; do not override)
- RR, 1, 1 = round-robin arbitration; 0 = fixed priority, highest index wins

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  N  request pulses or levels; bit i set in a cycle makes index i pending
- y  out  W  encoded index of the current grant
- out_valid  out  1  `y` holds a valid grant
- out_ready  in  1  consumer accepts `y` this cycle
- pending  out  N  registered sticky pending vector (status)
- idle  out  1  high when pending==0 and out_valid==0

Behaviour:
- Reset (async assert, sync deassert by the surrounding design): pending=0, y=0, out_valid=0, last_ptr=N-1 (the first RR search starts at index 0), FSM=EMPTY. Reset mid-operation drops every pending request and any unaccepted grant.
- Candidate vector cand = pending | req. New requests are visible to arbitration in the same cycle.
- Load condition: load = (state==EMPTY) || (out_valid && out_ready).
- FSM has 2 states:
  - EMPTY: out_valid=0. If load and cand≠0, go to FULL.
  - FULL: out_valid=1. On out_ready: if cand'≠0, stay in FULL with a new y; otherwise go to EMPTY. Without out_ready: stay in FULL.
- Accept cycle: cand' = cand with the bit of the accepted y cleared, unless req asserts that same bit again in this cycle. Re-request wins and the bit stays pending.
- On load with cand'≠0:
  - Select index g. If RR=1, g is the first set bit of cand' searching upward from last_ptr+1 modulo N (wrap N-1→0). If RR=0, g is the highest set bit.
  - At the clock edge: y←g, out_valid←1, last_ptr←g.
  - pending←cand' with bit g cleared.
- Not loading (FULL, out_ready=0): y and out_valid hold stable; pending←pending | req. Requests accumulate without loss and a duplicate of a pending bit merges into it. A request for the index currently shown in y becomes pending again.
- Latency: req at edge k with the port EMPTY gives out_valid=1 and the correct y after edge k. This is a 1-cycle registered latency. With out_ready held at 1 and continuous requests, one grant is issued per cycle.
- idle is combinational from the registers: idle = (pending==0) && !out_valid.
- Width rules: y is W bits. Modulo-N pointer arithmetic is done in W bits; N is a power of 2, so wrap is natural overflow.

Decomposition:
- Package encoder_pkg holds:
  - typedef enum logic {ENC_EMPTY, ENC_FULL} enc_state_t
  - localparam ENC_N_DEFAULT=4
  - function first_set_from(vec, start), returning index plus a found flag
- Sub-module rr_pick (N, RR) is a natural split: purely combinational, input cand and last_ptr, outputs g and any. It can be unit-tested independently.

Test Plan:
- Reset then single request: rst_n low 2 cycles, release; req=4'b0001 for 1 cycle, out_ready=1 → next cycle y=2'd0, out_valid=1; following cycle out_valid=0, idle=1.
- Round-robin fairness: RR=1, hold req=4'b1111, out_ready=1 → y sequence 0,1,2,3,0,1 on consecutive cycles, out_valid continuously 1.
- Backpressure: out_ready=0; req=4'b0100, then req=4'b1010 → y=2 holds stable; pending=4'b1010. Raise out_ready → y=3, then y=1, then out_valid=0.
- Fixed priority: RR=0, hold req=4'b0110, out_ready=1 → y=2 every cycle and index 1 never granted. Drop req → y=1 granted once from pending, then empty.
- Re-request of granted index: out_valid=1, y=1; in the accept cycle req=4'b0010 → next y=1 again (bit not lost); pending=0 afterwards.
- Reset mid-operation: pending=4'b1011, out_valid=1; pulse rst_n low asynchronously mid-cycle → pending=0, out_valid=0, y=0 immediately. After release, req=4'b1000 → y=3 (RR search restarts from 0).
